updown_pingpong_ctrl: RTL and testbench
=======================================

// Module: updown_pingpong_ctrl
// PURPOSE
//  Direction controller for up_down_counter: reads back its count and drives its up_down input so the
//  count sweeps back and forth between two programmable limits without overshoot or wrap-around.
//  Sits beside the counter in a feedback loop (count_in <- counter, up_down -> counter); same clock.
//  Also reports turn events and a saturating turn tally for downstream status logic.
// PARAMETERS
//  W       4  count width; must match the counter
//  TURN_W  8  width of the saturating turn tally
// PORTS
//  clk       in   1       rising-edge clock, shared with the counter
//  rst       in   1       reset: synchronous, active-low
//  en        in   1       1 = run ping-pong; 0 = idle (direction frozen)
//  lo_lim    in   W       lower sweep limit (latched, see BEHAVIOUR)
//  hi_lim    in   W       upper sweep limit (latched)
//  count_in  in   W       current counter value
//  up_down   out  1       registered direction to counter: 1 = up, 0 = down
//  turn      out  1       1-cycle pulse when direction reverses inside the window
//  turns     out  TURN_W  count of turn pulses since reset, saturates at all-ones
//  fault     out  1       latched limits invalid (lo >= hi)
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low. All state updates on posedge clk.
//  Reset (rst=0 at an edge): state=IDLE, up_down=1, turn=0, turns=0, fault=0, lo_q=0, hi_q=2^W-1.
//   Reset mid-sweep overrides everything, including a turn decided in the same cycle.
//  Limit latch: lo_q/hi_q load from lo_lim/hi_lim on the edge that leaves IDLE (en=1 while IDLE).
//   Limit changes while running are ignored until en drops and rises again.
//  States (package enum): IDLE, SEEK, RUN, FAULT.
//   IDLE : up_down held. en=1 -> latch limits; next = FAULT if lo_lim>=hi_lim, else SEEK/RUN per count_in.
//   SEEK : count_in < lo_q -> up_down<=1; count_in > hi_q -> up_down<=0; count in [lo_q,hi_q] -> RUN.
//   RUN  : direction rule (evaluated on the sampled count_in, registered at the edge):
//          up_down=1 & count_in >= hi_q-1 -> up_down<=0, turn<=1
//          up_down=0 & count_in <= lo_q+1 -> up_down<=1, turn<=1
//          otherwise hold, turn<=0. count_in outside window -> SEEK (no turn pulse).
//   FAULT: fault=1, up_down<=1 (counter free-runs up); leaves only via en=0 -> IDLE (fault clears).
//   Any state: en=0 -> IDLE on next edge, turn<=0.
//  Latency: anticipation by one count compensates the one-cycle register delay, so the counter peaks
//   exactly at hi_q and troughs exactly at lo_q; count never leaves [lo_q,hi_q] in RUN, never wraps.
//  hi_q-lo_q == 1: direction reverses every cycle, counter alternates lo_q/hi_q, turn high every cycle.
//  turns: +1 per turn pulse, holds at 2^TURN_W-1. Compares are unsigned, W bits; hi_q-1 / lo_q+1
//   computed in W+1 bits (no wrap since lo_q<hi_q is guaranteed outside FAULT).
// STRUCTURE
//  Package updown_pkg: state_t enum {IDLE,SEEK,RUN,FAULT}, default W, reset limit constants.
//  One sub-module: sat_counter #(TURN_W) (inc, clr -> saturating value) for turns.
//  Remaining FSM, limit registers and direction register flat in this module.
// TESTING (bench instantiates this block closed-loop with up_down_counter)
//  lo=3, hi=9, en=1 after reset -> count 0..9 then 8..3,4..9; never <3 or >9 after entry; turn at each peak.
//  lo=6, hi=7 -> count alternates 6,7,6,7; turn=1 every cycle; turns increments every cycle.
//  lo=9, hi=9 (and lo=10, hi=4) -> fault=1, up_down=1, counter wraps 15->0; en=0 -> fault=0, IDLE.
//  Change hi_lim 9->12 mid-sweep with en=1 -> peak stays 9; toggle en 0->1 -> peak becomes 12.
//  Assert rst=0 on the cycle a turn is due -> next cycle up_down=1, turn=0, turns=0, state IDLE.
//  TURN_W=2, run >=4 turns -> turns stops at 3.

Source files
------------

// File: rtl/updown_pkg.sv
// Package for the ping-pong direction controller.
// Holds the FSM state encoding, the default widths and the limit values
// loaded at reset (full counter range: lo = 0, hi = all ones).
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int unsigned DEF_W      = 4;
  localparam int unsigned DEF_TURN_W = 8;

  // Reset limits. They are wide, and callers slice them to the count width.
  localparam logic [31:0] RST_LO = 32'h0000_0000;
  localparam logic [31:0] RST_HI = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the turn tally.
// Ports:
//   clk    in  1      rising-edge clock
//   clr    in  1      synchronous clear. It has priority over inc.
//   inc    in  1      add one unless already at all-ones
//   value  out W      current tally
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/updown_pingpong_ctrl.sv
// Direction controller for an up/down counter in a feedback loop.
// The controller reads back the count and drives the counter's up_down input.
// The count then sweeps between the latched limits lo_q and hi_q. It does not
// overshoot and it does not wrap.
// Ports:
//   clk        in  1       rising-edge clock, shared with the counter
//   rst        in  1       synchronous, active-low reset
//   en         in  1       1 = run ping-pong, 0 = idle with the direction frozen
//   lo_lim     in  W       lower limit. It is latched on the edge that leaves IDLE.
//   hi_lim     in  W       upper limit. It is latched on the edge that leaves IDLE.
//   count_in   in  W       current counter value
//   up_down    out 1       registered direction: 1 = up, 0 = down
//   turn       out 1       one-cycle pulse on each reversal inside the window
//   turns      out TURN_W  saturating count of turn pulses since reset
//   fault      out 1       the latched limits are invalid (lo >= hi)
//   state_dbg  out 2       current FSM state, for observation
//
// Handshake: there is no valid/ready. The counter consumes up_down on every
// clock edge. The controller samples count_in on every edge.
module updown_pingpong_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned TURN_W = DEF_TURN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      lo_lim,
  input  logic [W-1:0]      hi_lim,
  input  logic [W-1:0]      count_in,
  output logic              up_down,
  output logic              turn,
  output logic [TURN_W-1:0] turns,
  output logic              fault,
  output state_t            state_dbg
);

  state_t       state_q, state_d;
  logic         up_q, up_d;
  logic         turn_q, turn_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;

  // The threshold compares use one extra bit. Outside FAULT we know lo_q < hi_q,
  // so hi_q-1 and lo_q+1 cannot wrap.
  logic [W:0] cnt_x;
  logic [W:0] hi_m1;
  logic [W:0] lo_p1;
  logic       in_win;
  logic       hit_top;
  logic       hit_bot;

  assign cnt_x   = {1'b0, count_in};
  assign hi_m1   = {1'b0, hi_q} - (W+1)'(1);
  assign lo_p1   = {1'b0, lo_q} + (W+1)'(1);
  assign in_win  = (count_in >= lo_q) && (count_in <= hi_q);

  // The new direction takes effect one edge after the counter has already
  // moved. Turning one count early therefore makes the counter peak at hi_q
  // and trough at lo_q.
  assign hit_top = up_q  && (cnt_x >= hi_m1);
  assign hit_bot = !up_q && (cnt_x <= lo_p1);

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    turn_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          lo_d = lo_lim;
          hi_d = hi_lim;
          if (lo_lim >= hi_lim) begin
            state_d = FAULT;
            up_d    = 1'b1;
          end else if ((count_in < lo_lim) || (count_in > hi_lim)) begin
            state_d = SEEK;
          end else begin
            state_d = RUN;
          end
        end

        SEEK: begin
          if (count_in < lo_q) begin
            up_d = 1'b1;
          end else if (count_in > hi_q) begin
            up_d = 1'b0;
          end else begin
            // The count can enter the window one step from a limit. This
            // happens every cycle when the window is two counts wide. Apply
            // the turn rule on the entry edge so the counter does not step past
            // the limit.
            state_d = RUN;
            if (hit_top) begin
              up_d   = 1'b0;
              turn_d = 1'b1;
            end else if (hit_bot) begin
              up_d   = 1'b1;
              turn_d = 1'b1;
            end
          end
        end

        RUN: begin
          if (!in_win) begin
            state_d = SEEK;
          end else if (hit_top) begin
            up_d   = 1'b0;
            turn_d = 1'b1;
          end else if (hit_bot) begin
            up_d   = 1'b1;
            turn_d = 1'b1;
          end
        end

        FAULT: begin
          up_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      up_q    <= 1'b1;
      turn_q  <= 1'b0;
      lo_q    <= RST_LO[W-1:0];
      hi_q    <= RST_HI[W-1:0];
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      turn_q  <= turn_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // The tally advances on the same edge that raises turn. Reset clears it, and
  // the clear wins over a turn decided in the same cycle.
  sat_counter #(
    .W (TURN_W)
  ) u_turns (
    .clk   (clk),
    .clr   (~rst),
    .inc   (turn_d),
    .value (turns)
  );

  assign up_down   = up_q;
  assign turn      = turn_q;
  assign fault     = (state_q == FAULT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_updown_pingpong_ctrl.sv
// Closed-loop bench. Each controller drives its own wrapping 4-bit up/down
// counter. Two controllers share the inputs: one has an 8-bit tally and the
// other has a 2-bit tally, to exercise saturation.
module tb_updown_pingpong_ctrl;
  import updown_pkg::*;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] lo_lim;
  logic [W-1:0] hi_lim;

  logic [W-1:0] cnt;
  logic         up_down;
  logic         turn;
  logic [7:0]   turns;
  logic         fault;
  state_t       state;

  logic [W-1:0] cnt2;
  logic         up_down2;
  logic         turn2;
  logic [1:0]   turns2;
  logic         fault2;
  state_t       state2;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs and counters ----------------
  updown_pingpong_ctrl #(.W(W), .TURN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .lo_lim(lo_lim), .hi_lim(hi_lim),
    .count_in(cnt), .up_down(up_down), .turn(turn), .turns(turns),
    .fault(fault), .state_dbg(state)
  );

  updown_pingpong_ctrl #(.W(W), .TURN_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .lo_lim(lo_lim), .hi_lim(hi_lim),
    .count_in(cnt2), .up_down(up_down2), .turn(turn2), .turns(turns2),
    .fault(fault2), .state_dbg(state2)
  );

  always @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end

  always @(posedge clk) begin
    if (!rst) cnt2 <= '0;
    else      cnt2 <= up_down2 ? cnt2 + 4'd1 : cnt2 - 4'd1;
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [W-1:0] e;
    logic [W-1:0] mx, mn, prev;
    logic         wrap_seen, down_seen;
    int           t;

    rst = 1'b0; en = 1'b0; lo_lim = '0; hi_lim = '0;
    tick();
    tick();
    chk("rst_up", up_down, 1);
    chk("rst_turn", turn, 0);
    chk("rst_turns", turns, 0);
    chk("rst_fault", fault, 0);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_cnt", cnt, 0);

    // Sweep 3..9 starting from count 0. The count climbs to 9, descends to 3,
    // then climbs to 9 again. Turns occur on the edges where the counter
    // reaches 9, 3 and 9.
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd8,
              4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    rst = 1'b1; en = 1'b1; lo_lim = 4'd3; hi_lim = 4'd9;
    for (int i = 0; i < 21; i++) begin
      tick();
      e = exp_q.pop_front();
      chk($sformatf("sweep_cnt[%0d]", i), cnt, e);
      chk($sformatf("sweep_turn[%0d]", i), turn, (i == 8 || i == 14 || i == 20) ? 1 : 0);
      if (i == 0) chk("sweep_seek", 32'(state), 32'(SEEK));
      if (i == 3) chk("sweep_run", 32'(state), 32'(RUN));
    end
    chk("sweep_turns", turns, 3);

    // hi_lim changes while running. It must have no effect until en is toggled.
    hi_lim = 4'd12;
    mx = cnt; mn = cnt;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cnt > mx) mx = cnt;
      if (cnt < mn) mn = cnt;
    end
    chk("midchg_max", mx, 9);
    chk("midchg_min", mn, 3);
    chk("midchg_turns", turns, 5);
    chk("midchg_turn", turn, 1);

    en = 1'b0;
    tick();
    chk("pause_state", 32'(state), 32'(IDLE));
    chk("pause_turn", turn, 0);
    chk("pause_up", up_down, 0);
    chk("pause_cnt", cnt, 8);

    en = 1'b1;
    tick();
    chk("relatch_state", 32'(state), 32'(RUN));
    chk("relatch_cnt", cnt, 7);
    mx = cnt; mn = cnt;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cnt > mx) mx = cnt;
      if (cnt < mn) mn = cnt;
    end
    chk("relatch_max", mx, 12);
    chk("relatch_min", mn, 3);

    // Invalid limits, lo == hi. The controller must fault and force the
    // direction up, so the counter wraps.
    en = 1'b0;
    tick();
    lo_lim = 4'd9; hi_lim = 4'd9; en = 1'b1;
    tick();
    chk("fault_eq", fault, 1);
    chk("fault_eq_state", 32'(state), 32'(FAULT));
    chk("fault_eq_up", up_down, 1);
    wrap_seen = 1'b0; down_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev = cnt;
      tick();
      if (prev == 4'd15 && cnt == 4'd0) wrap_seen = 1'b1;
      if (!up_down) down_seen = 1'b1;
    end
    chk("fault_wrap", wrap_seen, 1);
    chk("fault_never_down", down_seen, 0);
    chk("fault_held", fault, 1);
    en = 1'b0;
    tick();
    chk("fault_clear", fault, 0);
    chk("fault_clear_state", 32'(state), 32'(IDLE));

    // Invalid limits, lo > hi.
    lo_lim = 4'd10; hi_lim = 4'd4; en = 1'b1;
    tick();
    chk("fault_gt", fault, 1);
    chk("fault_gt_up", up_down, 1);
    en = 1'b0;
    tick();
    chk("fault_gt_clear", fault, 0);

    // Two-count window, 6..7. Starting from 0 the controller seeks up. From
    // then on it turns every cycle, and the 2-bit tally saturates at 3.
    rst = 1'b0;
    tick();
    rst = 1'b1; lo_lim = 4'd6; hi_lim = 4'd7; en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("pp_cnt0", cnt, 7);
    chk("pp_up0", up_down, 0);
    chk("pp_turn0", turn, 1);
    chk("pp_turns0", turns, 1);
    chk("pp_state0", 32'(state), 32'(RUN));
    for (int k = 1; k <= 8; k++) begin
      tick();
      t = (k + 1 > 3) ? 3 : k + 1;
      chk($sformatf("pp_cnt[%0d]", k), cnt, (k % 2) ? 6 : 7);
      chk($sformatf("pp_turn[%0d]", k), turn, 1);
      chk($sformatf("pp_turns[%0d]", k), turns, k + 1);
      chk($sformatf("pp_sat[%0d]", k), turns2, t);
    end

    // Reset on a cycle where a turn is due. Reset must win.
    rst = 1'b0;
    tick();
    chk("rstturn_up", up_down, 1);
    chk("rstturn_turn", turn, 0);
    chk("rstturn_turns", turns, 0);
    chk("rstturn_sat", turns2, 0);
    chk("rstturn_state", 32'(state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
